// File: rtl/onehot_rr_arbiter.sv
// Eight-way round-robin arbiter with a registered one-hot grant and binary owner index.
// Define ARB_TIMEOUT_EN to add a hold-time limit that forces release after HOLD_MAX grant cycles.
module onehot_rr_arbiter #(
  parameter int N        = 8,
  parameter int IDX_W    = 3,
  parameter int HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t           state, state_d;
  logic [IDX_W-1:0] ptr, ptr_d;
  logic [IDX_W-1:0] idx_d;
  logic             valid_d;
  logic [N-1:0]     gnt_d;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;
  logic             win_found;
  logic             release_req;

`ifdef ARB_TIMEOUT_EN
  localparam int               CNT_W     = $clog2(HOLD_MAX) + 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] hold_cnt, cnt_d;
  logic             timeout_d;
`endif

  // Rotating priority search: ptr+1 first, ptr itself last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    win_found = 1'b0;
    win_idx   = ptr;
    cand      = '0;
    for (int i = 1; i <= N; i++) begin
      cand = ptr + IDX_W'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign release_req = done || !req[gnt_idx];

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    idx_d   = gnt_idx;
    valid_d = gnt_valid;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = hold_cnt;
    timeout_d = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          ptr_d   = win_idx;
          idx_d   = win_idx;
          valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        if (release_req) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        // Forced release leaves ptr on the offender so it drops to lowest priority.
        else if (hold_cnt == HOLD_LAST) begin
          state_d   = IDLE;
          valid_d   = 1'b0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = hold_cnt + 1'b1;
        end
`endif
      end
    endcase
    gnt_d = valid_d ? (N'(1) << idx_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= IDX_W'(N - 1);
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      gnt       <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt  <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state     <= state_d;
      ptr       <= ptr_d;
      gnt_idx   <= idx_d;
      gnt_valid <= valid_d;
      gnt       <= gnt_d;
`ifdef ARB_TIMEOUT_EN
      hold_cnt  <= cnt_d;
      timeout   <= timeout_d;
`endif
    end
  end

`ifndef ARB_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

endmodule

// File: doc/onehot_rr_arbiter.md
# onehot_rr_arbiter

Round-robin arbiter sharing a single resource between 8 requesters, issuing a registered one-hot grant plus its binary index. It sits ahead of the binary-to-one-hot decode path: the winning index is kept as a 3-bit pointer and decoded to the 8-bit grant vector. Grant is held until the owner releases, then priority rotates past the last winner.

## Interface
- N, 8, number of requesters; fixed at 8 (one-hot width)
- IDX_W, 3, index width, log2(N)
- HOLD_MAX, 16, max cycles a grant may be held (used only with timeout feature)
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk
- req  input  8  request vector, bit i = requester i
- done  input  1  owner releases resource (single-cycle pulse)
- gnt  output  8  one-hot grant, all-zero when idle
- gnt_idx  output  3  binary index of current owner, valid when gnt_valid=1
- gnt_valid  output  1  resource currently granted
- timeout  output  1  one-cycle pulse on forced release

## Operation
- States: IDLE, GRANT.
- IDLE: if any req bit set, pick first set bit searching ptr+1, ptr+2, … wrapping modulo 8; load gnt_idx, gnt = decode(gnt_idx), gnt_valid=1, ptr <= winner, go GRANT. If req==0, stay IDLE.
- GRANT: outputs held stable. Release when done=1 OR req[gnt_idx]=0 (requester withdraws). On release: gnt=0, gnt_valid=0, go IDLE.
- Pointer ptr (3 bits) holds last winner; reset value 7 so requester 0 has highest priority after reset.
- Wrap: after winner 7, search starts at 0.
- done while IDLE: ignored.
- req bits other than owner's changing during GRANT: no effect.
- gnt is always decode(gnt_idx) when gnt_valid=1, else 8'h00; never more than one bit set.

## Timing
- Reset (rst_n=0 at clock edge): state=IDLE, gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0, ptr=3'd7, hold counter=0. Reset mid-grant drops grant on that edge.
- Request-to-grant latency: 1 cycle (req sampled at edge k, gnt valid after edge k).
- Release-to-idle: gnt deasserts after the edge sampling done=1.
- One mandatory dead cycle after every release (IDLE cycle); next grant appears the cycle after, so minimum grant-to-grant spacing is 2 cycles.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- Macro ARB_TIMEOUT_EN.
- Defined: hold counter (width ≥ log2(HOLD_MAX)+1) clears on entering GRANT, increments each GRANT cycle; when it reaches HOLD_MAX-1 with no release, grant is forced off on next edge, timeout pulses 1 for exactly one cycle (same cycle gnt drops), state goes IDLE, ptr keeps the timed-out index so it loses priority. If done or req withdrawal coincides with the limit cycle, normal release, timeout stays 0.
- Undefined: no counter; grant held indefinitely until release; timeout tied to 0.

## Test plan
- Reset then req=8'h01 -> after 1 edge gnt=8'h01, gnt_idx=0, gnt_valid=1; reset mid-grant -> gnt=8'h00, gnt_valid=0 after next edge.
- req=8'hFF held, pulse done each grant -> grants 8'h01,8'h02,…,8'h80,8'h01 with one idle cycle between each (wrap verified).
- Owner 3 granted, req changes to 8'h81 without done -> owner 3 dropped, next grant 8'h80 (idx 7), then 8'h01.
- done pulsed while IDLE with req=0 -> no grant, outputs stay zero; req[owner] drop and done same cycle -> single release.
- Random req/done for 10k cycles -> gnt always one-hot or zero, gnt==decode(gnt_idx) when valid, every persistent requester served within 8 grants.
- With ARB_TIMEOUT_EN, HOLD_MAX=16, req=8'h04 held, no done -> gnt drops after 16 GRANT cycles, timeout=1 for one cycle; with req=8'h0C next grant is 8'h08.
